// File: rtl/icu_ibuf.sv
// Dual-lane instruction buffer between decode and hazard-gated issue: 2-in / 2-out FIFO with flush.
// Optional ICU_IBUF_BYPASS_EN: zero-latency pass-through of incoming bundles while the buffer is empty.
module icu_ibuf #(
    parameter  int DATA_W = 160,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [1:0]        in_valid_i,
    input  logic [DATA_W-1:0] in_data0_i,
    input  logic [DATA_W-1:0] in_data1_i,
    output logic              in_ready_o,
    output logic [1:0]        out_valid_o,
    output logic [DATA_W-1:0] out_data0_o,
    output logic [DATA_W-1:0] out_data1_o,
    input  logic [1:0]        issue_i,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_p1, wr_ptr_p1;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        in_valid_legal;
    logic [1:0]        push_cnt, pop_cnt, wr_cnt, rd_pop;
    logic              wr_en0, wr_en1;
    logic [DATA_W-1:0] wr_data0, wr_data1;

    assign rd_ptr_p1  = rd_ptr_q + PTR_W'(1);
    assign wr_ptr_p1  = wr_ptr_q + PTR_W'(1);
    assign in_ready_o = in_ready_q;
    assign count_o    = count_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        in_valid_legal = in_valid_i[0] ? in_valid_i : 2'b00;
        push_cnt       = 2'd0;
        out_valid_o    = {count_q >= CNT_W'(2), count_q != '0};
        out_data0_o    = mem_q[rd_ptr_q];
        out_data1_o    = mem_q[rd_ptr_p1];
        wr_data0       = in_data0_i;
        wr_data1       = in_data1_i;

        if (in_ready_q && !flush_i) begin
            push_cnt = {1'b0, in_valid_legal[1]} + {1'b0, in_valid_legal[0]};
        end

`ifdef ICU_IBUF_BYPASS_EN
        if (count_q == '0 && !flush_i) begin
            out_valid_o = in_ready_q ? in_valid_legal : 2'b00;
            out_data0_o = in_data0_i;
            out_data1_o = in_data1_i;
        end
`endif

        // Inst2 may only leave together with inst1, so a lone issue_i[1] pops nothing.
        pop_cnt = {1'b0, issue_i[0] & out_valid_o[0]}
                + {1'b0, issue_i[0] & issue_i[1] & out_valid_o[1]};
        wr_cnt  = push_cnt;
        rd_pop  = pop_cnt;

`ifdef ICU_IBUF_BYPASS_EN
        // Bundles issued straight from the inputs never land in storage; survivors shift down a lane.
        if (count_q == '0 && !flush_i) begin
            wr_cnt   = push_cnt - pop_cnt;
            rd_pop   = 2'd0;
            wr_data0 = pop_cnt[0] ? in_data1_i : in_data0_i;
        end
`endif

        wr_en0   = (wr_cnt != 2'd0);
        wr_en1   = (wr_cnt == 2'd2);
        count_d  = count_q + CNT_W'(wr_cnt) - CNT_W'(rd_pop);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt);

        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end

        // Ready needs room for a full two-lane push next cycle.
        in_ready_d = (count_d <= CNT_W'(DEPTH - 2));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            in_ready_q <= in_ready_d;
        end
    end

    // NOTE: storage is deliberately not reset; out_valid_o masks stale entries and it maps to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en0) mem_q[wr_ptr_q]  <= wr_data0;
        if (wr_en1) mem_q[wr_ptr_p1] <= wr_data1;
    end

endmodule

// File: tb/tb_icu_ibuf.sv
// Self-checking bench for icu_ibuf: vector table plus hand-written wrap, fill-latency and reset sequences.
module tb_icu_ibuf;

    localparam int DATA_W = 160;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst, flush_i;
    logic [1:0]        in_valid_i, issue_i, out_valid_o;
    logic [DATA_W-1:0] in_data0_i, in_data1_i, out_data0_o, out_data1_o;
    logic              in_ready_o;
    logic [CNT_W-1:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    icu_ibuf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_data0_i (in_data0_i),
        .in_data1_i (in_data1_i),
        .in_ready_o (in_ready_o),
        .out_valid_o(out_valid_o),
        .out_data0_o(out_data0_o),
        .out_data1_o(out_data1_o),
        .issue_i    (issue_i),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic [1:0] vin;
        int         t0;
        int         t1;
        logic [1:0] iss;
        logic [1:0] ev;
        int         e0;
        int         e1;
        int         ecnt;
        logic       erdy;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [DATA_W-1:0] tg(input int n);
        tg = {5{32'(n) ^ 32'h5A5A_0000}};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic [1:0] vin,
                         input int t0, input int t1, input logic [1:0] iss);
        rst        = r;
        flush_i    = f;
        in_valid_i = vin;
        in_data0_i = tg(t0);
        in_data1_i = tg(t1);
        issue_i    = iss;
    endtask

    // Apply one cycle of stimulus, then idle the inputs and settle before sampling.
    task automatic step(input logic r, input logic f, input logic [1:0] vin,
                        input int t0, input int t1, input logic [1:0] iss);
        drive(r, f, vin, t0, t1, iss);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'b00, 0, 0, 2'b00);

        //            rst   flush vin    t0 t1 iss    ev     e0 e1 cnt rdy
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'b11, 1, 2, 2'b00, 2'b11, 1, 2, 2, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 3, 0, 2'b00, 2'b11, 1, 2, 3, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'b11, 4, 5, 2'b11, 2'b11, 3, 4, 3, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'b10, 9, 9, 2'b10, 2'b11, 3, 4, 3, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'b01, 6, 0, 2'b01, 2'b11, 4, 5, 3, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'b11, 7, 8, 2'b00, 2'b11, 4, 5, 5, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 2'b01, 10, 0, 2'b00, 2'b11, 4, 5, 6, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'b01, 11, 0, 2'b00, 2'b11, 4, 5, 7, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'b01, 12, 0, 2'b00, 2'b11, 4, 5, 7, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 0, 0, 2'b01, 2'b11, 5, 6, 6, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 2'b11, 13, 14, 2'b11, 2'b00, 0, 0, 0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].t0, vecs[i].t1, vecs[i].iss);
            check($sformatf("v%0d.valid", i), DATA_W'(out_valid_o), DATA_W'(vecs[i].ev));
            check($sformatf("v%0d.count", i), DATA_W'(count_o), DATA_W'(vecs[i].ecnt));
            check($sformatf("v%0d.ready", i), DATA_W'(in_ready_o), DATA_W'(vecs[i].erdy));
            if (vecs[i].ev[0]) check($sformatf("v%0d.data0", i), out_data0_o, tg(vecs[i].e0));
            if (vecs[i].ev[1]) check($sformatf("v%0d.data1", i), out_data1_o, tg(vecs[i].e1));
        end

        // Fill latency observed on the push cycle itself, buffer empty.
        drive(1'b0, 1'b0, 2'b01, 20, 0, 2'b00);
        #1;
`ifdef ICU_IBUF_BYPASS_EN
        check("fill.bypass_valid", DATA_W'(out_valid_o), DATA_W'(2'b01));
        check("fill.bypass_data0", out_data0_o, tg(20));
`else
        check("fill.no_early_valid", DATA_W'(out_valid_o), DATA_W'(2'b00));
`endif
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        #1;
        check("fill.valid_next", DATA_W'(out_valid_o), DATA_W'(2'b01));
        check("fill.data0_next", out_data0_o, tg(20));
        for (int k = 21; k <= 26; k++) step(1'b0, 1'b0, 2'b01, k, 0, 2'b00);
        check("fill7.count", DATA_W'(count_o), DATA_W'(7));
        check("fill7.ready", DATA_W'(in_ready_o), DATA_W'(0));

        // Drain three, then push across the 7->0 pointer wrap.
        step(1'b0, 1'b0, 2'b00, 0, 0, 2'b11);
        step(1'b0, 1'b0, 2'b00, 0, 0, 2'b01);
        check("pre_wrap.count", DATA_W'(count_o), DATA_W'(4));
        step(1'b0, 1'b0, 2'b11, 27, 28, 2'b00);
        check("wrap.count6", DATA_W'(count_o), DATA_W'(6));
        check("wrap.ready6", DATA_W'(in_ready_o), DATA_W'(1));
        step(1'b0, 1'b0, 2'b01, 29, 0, 2'b00);
        check("wrap.count7", DATA_W'(count_o), DATA_W'(7));
        for (int k = 0; k < 7; k++) begin
            check($sformatf("drain%0d.valid0", k), DATA_W'(out_valid_o[0]), DATA_W'(1));
            check($sformatf("drain%0d.data0", k), out_data0_o, tg(23 + k));
            step(1'b0, 1'b0, 2'b00, 0, 0, 2'b01);
        end
        check("drain.count", DATA_W'(count_o), DATA_W'(0));
        check("drain.valid", DATA_W'(out_valid_o), DATA_W'(2'b00));

        // Reset while a push and pop are in flight.
        step(1'b0, 1'b0, 2'b11, 30, 31, 2'b00);
        check("prerst.count", DATA_W'(count_o), DATA_W'(2));
        step(1'b1, 1'b0, 2'b11, 32, 33, 2'b01);
        check("rst.count", DATA_W'(count_o), DATA_W'(0));
        check("rst.valid", DATA_W'(out_valid_o), DATA_W'(2'b00));
        check("rst.ready", DATA_W'(in_ready_o), DATA_W'(1));

`ifdef ICU_IBUF_BYPASS_EN
        drive(1'b0, 1'b0, 2'b11, 40, 41, 2'b01);
        #1;
        check("byp.valid_same", DATA_W'(out_valid_o), DATA_W'(2'b11));
        check("byp.data0_same", out_data0_o, tg(40));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'b00, 0, 0, 2'b00);
        #1;
        check("byp.count", DATA_W'(count_o), DATA_W'(1));
        check("byp.valid_next", DATA_W'(out_valid_o), DATA_W'(2'b01));
        check("byp.data0_next", out_data0_o, tg(41));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
